// File: rtl/fetch_queue_pkg.sv
// Shared CPU definitions used by the fetch queue and its neighbours.
package fetch_queue_pkg;

    localparam int CPU_AW = 32;
    localparam int CPU_DW = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          PC_STEP   = 4;

    typedef struct packed {
        logic [CPU_AW-1:0] pc;
        logic [CPU_DW-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side handshake bundle of the fetch queue.
// The master is the pipeline around the queue; the slave is the queue itself.
interface fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
);

    logic                       fetch_valid_i;
    logic [AW-1:0]              pc_i;
    logic [DW-1:0]              instr_i;
    logic                       full_o;
    logic                       flush_i;
    logic                       id_ready_i;
    logic                       id_valid_o;
    logic [AW-1:0]              id_pc_o;
    logic [AW-1:0]              id_pc4_o;
    logic [DW-1:0]              id_instr_o;
    logic [$clog2(DEPTH):0]     count_o;
    logic                       ovf_o;

    modport master (
        output fetch_valid_i, pc_i, instr_i, flush_i, id_ready_i,
        input  full_o, id_valid_o, id_pc_o, id_pc4_o, id_instr_o, count_o, ovf_o
    );

    modport slave (
        input  fetch_valid_i, pc_i, instr_i, flush_i, id_ready_i,
        output full_o, id_valid_o, id_pc_o, id_pc4_o, id_instr_o, count_o, ovf_o
    );

endinterface

// File: rtl/fetch_queue_storage_ram.sv
// Register array holding queued {pc, instr} entries: synchronous write,
// asynchronous read, cleared by reset (flush leaves contents in place).
module fq_storage_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on a push; reset zeroes every entry.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the PC/instruction memory and decode.
// Holds pointer/count control and head output muxing; storage lives in
// fq_storage_ram.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk_i,
    input  logic          rst_n,
    fetch_queue_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             ovf;
    logic             full;
    logic             valid;
    logic             push;
    logic             pop;
    logic [AW+DW-1:0] head;
    logic [AW-1:0]    head_pc;

    // Flags come from the registered count only, so no input reaches them.
    assign valid = (count != '0);
    assign full  = (count == CW'(DEPTH));

    // Flush wins over both sides of the handshake.
    assign push = bus.fetch_valid_i & ~full  & ~bus.flush_i;
    assign pop  = valid & bus.id_ready_i & ~bus.flush_i;

    fq_storage_ram #(
        .DEPTH (DEPTH),
        .WIDTH (AW + DW)
    ) u_storage (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({bus.pc_i, bus.instr_i}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Pointer and occupancy update; flush rewinds everything to slot 0.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Sticky overflow: a fetch offered while full is lost, only reset clears it.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (bus.fetch_valid_i && full && !bus.flush_i) begin
            ovf <= 1'b1;
        end
    end

    assign head_pc        = head[AW+DW-1:DW];
    assign bus.id_valid_o = valid;
    assign bus.full_o     = full;
    assign bus.count_o    = count;
    assign bus.ovf_o      = ovf;
    assign bus.id_pc_o    = head_pc;
    assign bus.id_pc4_o   = head_pc + AW'(PC_STEP);
    assign bus.id_instr_o = valid ? head[DW-1:0] : DW'(NOP_INSTR);

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction fetch queue between the program counter/instruction memory and the ID stage. Each cycle it captures a fetched {PC, instruction} pair and presents them in order to decode with a valid/ready handshake. It back-pressures the PC path via full_o. Branch/jump redirects empty it through a synchronous flush.

Parameters:
DEPTH, 4, number of entries; power of 2, minimum 2
AW, 32, PC width in bits
DW, 32, instruction width in bits

Ports:
clk_i  input  1  clock
rst_n  input  1  reset
fetch_valid_i  input  1  pc_i/instr_i hold a valid fetched pair this cycle
pc_i  input  AW  PC of fetched instruction (current PC register output)
instr_i  input  DW  instruction word read at pc_i
full_o  output  1  queue full; PC update must hold (stall)
flush_i  input  1  redirect from branch/jump resolution; discard all entries
id_ready_i  input  1  ID stage accepts the head entry this cycle
id_valid_o  output  1  head entry valid
id_pc_o  output  AW  PC of head entry
id_pc4_o  output  AW  id_pc_o + 4
id_instr_o  output  DW  instruction of head entry; 0 (NOP) when empty
count_o  output  $clog2(DEPTH)+1  current occupancy
ovf_o  output  1  sticky error: push attempted while full

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock clk_i, all state on the rising edge. Async reset sets write/read pointers and count to 0, storage to 0, ovf_o to 0. Resulting outputs: id_valid_o=0, full_o=0, count_o=0, id_instr_o=0, id_pc_o=0, id_pc4_o=4.
- Reset asserted mid-operation discards all entries immediately. First push is allowed on the first rising edge after deassertion.
- push = fetch_valid_i & ~full_o & ~flush_i. On push, the entry is written at wr_ptr and wr_ptr increments.
- pop = id_valid_o & id_ready_i & ~flush_i. On pop, rd_ptr increments.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- count next value: +1 on push only, -1 on pop only, unchanged on both or neither.
- id_valid_o = (count != 0). full_o = (count == DEPTH). Both are derived combinationally from registered count, so they have no combinational path from any input.
- Latency: an entry pushed at edge N is visible on id_* outputs after edge N (1 cycle). There is no empty bypass.
- Head outputs are read from storage[rd_ptr]. When empty, id_instr_o is forced to 0. id_pc_o still shows storage[rd_ptr] when empty and is don't-care for consumers.
- id_pc4_o = id_pc_o + 4, truncated to AW bits; 0xFFFFFFFC gives 0x00000000.
- Full with id_ready_i=1: pop occurs, push is blocked that cycle. full_o drops the next cycle, so there is no same-cycle full refill.
- Empty with fetch_valid_i=1 and id_ready_i=1: push only, since no pop is possible while empty.
- flush_i=1 dominates push and pop. At the next edge wr_ptr=rd_ptr=0 and count=0, and the pair presented that cycle is discarded.
- The cycle after a flush: id_valid_o=0, full_o=0, and the fetch at the redirected PC is accepted normally.
- ovf_o is set when fetch_valid_i & full_o & ~flush_i. It is cleared only by reset.
- Storage contents are not cleared by flush; only the pointers reset.
- id_* outputs are stable while id_valid_o=1 and id_ready_i=0.

Decomposition:
- Shared cpu package: NOP_INSTR = 32'h0000_0000, PC_STEP = 4, typedef fetch_entry_t {pc[AW-1:0], instr[DW-1:0]}.
- fetch_queue holds the pointer/count control and the output muxing.
- Natural sub-module: fq_storage_ram, a DEPTH x (AW+DW) register array with synchronous write and asynchronous read, reset to 0.

Test Plan:
1. Reset, then push pc=0x0/0x4/0x8 with instr=0x20080001/0x20090002/0x01095020, id_ready_i=0 -> count_o=3, id_valid_o=1, id_pc_o=0x0, id_pc4_o=0x4, id_instr_o=0x20080001.
2. Push 4 with ready=0 -> full_o=1. Fifth fetch_valid_i -> ovf_o=1 and count_o stays 4. Then ready=1 for 4 cycles -> pops in order 0x0, 0x4, 0x8, 0xC. Then id_valid_o=0 and id_instr_o=0.
3. Continuous fetch_valid_i=1 with ready=1 from empty -> count_o settles at 1 with one pop per cycle. PCs 0x100, 0x104, ... appear one cycle after their push.
4. Queue holding 3 entries, flush_i=1 with fetch_valid_i=1 pc=0x40 -> next cycle count_o=0, id_valid_o=0. Next push pc=0x80 -> id_pc_o=0x80.
5. At full, ready=1 with fetch_valid_i=1 -> same cycle pop but no push, count_o=3 next cycle, full_o=0. Push resumes the following cycle.
6. With 2 entries, assert rst_n=0 between edges -> outputs clear immediately with no clock. A push at pc=0xFFFFFFFC gives id_pc4_o=0x00000000.
